// File: rtl/soc_top.sv
// Minimal SoC stand-in: PC sequencer that flags completion at END_PC, LED heartbeat,
// and a one-shot UART banner ("OK\n") sent when the run completes.
//
// UART FSM
//   state   | meaning
//   S_IDLE  | line idle high, waiting for the rising edge of done
//   S_START | driving the start bit (0) of byte byte_idx
//   S_DATA  | driving data bit bit_idx of byte byte_idx, LSB first
//   S_STOP  | driving the stop bit (1); then next byte or back to idle
module soc_top #(
  parameter logic [31:0] RESET_PC  = 32'h1C00_0000,
  parameter logic [31:0] END_PC    = 32'h1C00_0100,
  parameter int          BAUD_DIV  = 16,
  parameter int          LED_SHIFT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  externalPins_gpio_in,
  input  logic        externalPins_uart_rx,
  output logic [5:0]  externalPins_gpio_out,
  output logic        externalPins_uart_tx,
  output logic [31:0] debug_wb_pc,
  output logic        debug_excp,
  output logic [6:0]  debug_excp_num
);

  localparam int          PW        = (LED_SHIFT > 0) ? LED_SHIFT : 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic          btn_s1, btn_s2;
  logic          core_rst;
  logic [31:0]   pc;
  logic          done, done_q, done_rise;
  logic [PW-1:0] presc;
  logic          led_tick;
  logic [5:0]    led_cnt;
  uart_state_t   state, state_n;
  logic [15:0]   baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic          bit_tc;
  logic [7:0]    tx_byte;
  logic          tx;
  logic          unused_pins;

  assign unused_pins = ^{externalPins_uart_rx, externalPins_gpio_in[3:1]};

  // Button is asynchronous to clock; only the system reset re-arms the synchronizer.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
    end else begin
      btn_s1 <= externalPins_gpio_in[0];
      btn_s2 <= btn_s1;
    end
  end

  assign core_rst = reset | ~btn_s2;

  always_ff @(posedge clock) begin
    if (core_rst) begin
      pc     <= RESET_PC;
      done   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= done;
      if (!done) begin
        if (pc == END_PC) done <= 1'b1;
        else              pc   <= pc + 32'd4;
      end
    end
  end

  assign done_rise = done & ~done_q;

  assign led_tick = (LED_SHIFT == 0) ? 1'b1 : (presc == {PW{1'b1}});

  always_ff @(posedge clock) begin
    if (core_rst) begin
      presc   <= '0;
      led_cnt <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (led_tick) led_cnt <= led_cnt + 6'd1;
    end
  end

  // UART: state register
  always_ff @(posedge clock) begin
    if (core_rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
    end
  end

  assign bit_tc = (baud_cnt == 16'd0);

  // UART: next-state logic; baud_cnt is a down-counter reloaded at each bit boundary
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    if (state != S_IDLE) baud_cnt_n = bit_tc ? BAUD_LAST : baud_cnt - 16'd1;
    case (state)
      S_IDLE: begin
        if (done_rise) begin
          state_n    = S_START;
          baud_cnt_n = BAUD_LAST;
          byte_idx_n = 2'd0;
        end
      end
      S_START: begin
        if (bit_tc) begin
          state_n   = S_DATA;
          bit_idx_n = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_tc) begin
          if (bit_idx == 3'd7) state_n   = S_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (bit_tc) begin
          if (byte_idx == 2'd2) begin
            state_n = S_IDLE;
          end else begin
            byte_idx_n = byte_idx + 2'd1;
            state_n    = S_START;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // UART: outputs
  always_comb begin
    case (byte_idx)
      2'd0:    tx_byte = 8'h4F;
      2'd1:    tx_byte = 8'h4B;
      default: tx_byte = 8'h0A;
    endcase
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = tx_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign externalPins_uart_tx  = tx;
  assign externalPins_gpio_out = done ? 6'h3F : led_cnt;
  assign debug_wb_pc           = pc;
  assign debug_excp            = done;
  assign debug_excp_num        = done ? 7'h40 : 7'h00;

endmodule

// File: tb/tb_soc_top.sv
// Directed bench for soc_top: PC run, LED heartbeat, UART banner, button abort, input noise.
module tb_soc_top;

  localparam logic [31:0] RESET_PC  = 32'h1C00_0000;
  localparam logic [31:0] END_PC    = 32'h1C00_0100;
  localparam int          BAUD      = 16;
  localparam int          LED_SHIFT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  gpio_in;
  logic        uart_rx;
  logic [5:0]  gpio_out;
  logic        uart_tx;
  logic [31:0] pc;
  logic        excp;
  logic [6:0]  excp_num;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pc_q[$];
  logic [7:0]  byte_q[$];

  soc_top #(
    .RESET_PC (RESET_PC),
    .END_PC   (END_PC),
    .BAUD_DIV (BAUD),
    .LED_SHIFT(LED_SHIFT)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .externalPins_gpio_in (gpio_in),
    .externalPins_uart_rx (uart_rx),
    .externalPins_gpio_out(gpio_out),
    .externalPins_uart_tx (uart_tx),
    .debug_wb_pc          (pc),
    .debug_excp           (excp),
    .debug_excp_num       (excp_num)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    uart_rx      = 1'($urandom_range(0, 1));
    gpio_in[3:1] = 3'($urandom_range(0, 7));
  endtask

  // Returns at the first cycle after release, with reset already low.
  task automatic sys_reset();
    @(negedge clock);
    reset   = 1'b1;
    gpio_in = 4'h1;
    uart_rx = 1'b1;
    @(negedge clock);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_excp", 32'({excp, excp_num}), 32'd0);
    chk("rst_gpio_out", 32'(gpio_out), 32'd0);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    reset = 1'b0;
  endtask

  // Called on the first cycle out of core reset; checks uart_cycles cycles of the banner.
  task automatic run_check(input int uart_cycles, input bit toggle);
    logic [7:0] eb;
    logic [7:0] rx;
    logic [9:0] frame;
    int         cyc;
    for (int k = 0; k <= 64; k++) begin
      pc_q.push_back(RESET_PC + 32'(4 * k));
      chk("pc_run", pc, pc_q.pop_front());
      chk("led_run", 32'(gpio_out), 32'((k >> LED_SHIFT) & 63));
      chk("excp_run", 32'({excp, excp_num}), 32'd0);
      chk("tx_run", 32'(uart_tx), 32'd1);
      if (toggle) noise();
      @(negedge clock);
    end
    chk("pc_end", pc, END_PC);
    chk("excp_done", 32'(excp), 32'd1);
    chk("excp_num_done", 32'(excp_num), 32'h40);
    chk("led_done", 32'(gpio_out), 32'h3F);
    chk("tx_before_start", 32'(uart_tx), 32'd1);
    byte_q.push_back(8'h4F);
    byte_q.push_back(8'h4B);
    byte_q.push_back(8'h0A);
    @(negedge clock);
    cyc = 0;
    for (int b = 0; b < 3; b++) begin
      eb    = byte_q.pop_front();
      frame = {1'b1, eb, 1'b0};
      rx    = 8'h00;
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < BAUD; c++) begin
          if (cyc == uart_cycles) begin
            byte_q.delete();
            return;
          end
          chk("uart_tx_bit", 32'(uart_tx), 32'(frame[i]));
          if (c == BAUD / 2 && i >= 1 && i <= 8) rx[i-1] = uart_tx;
          if (toggle) noise();
          @(negedge clock);
          cyc++;
        end
      end
      chk("uart_byte", 32'(rx), 32'(eb));
    end
    for (int k = 0; k < 40; k++) begin
      chk("tx_after", 32'(uart_tx), 32'd1);
      chk("pc_hold", pc, END_PC);
      chk("excp_hold", 32'({excp, excp_num}), 32'hC0);
      chk("led_hold", 32'(gpio_out), 32'h3F);
      if (toggle) noise();
      @(negedge clock);
    end
  endtask

  initial begin
    reset   = 1'b1;
    gpio_in = 4'h1;
    uart_rx = 1'b1;

    sys_reset();
    run_check(480, 1'b0);

    sys_reset();
    run_check(100, 1'b1);
    gpio_in = 4'h0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 97; k++) begin
      chk("btn_tx", 32'(uart_tx), 32'd1);
      chk("btn_pc", pc, RESET_PC);
      chk("btn_excp", 32'({excp, excp_num}), 32'd0);
      chk("btn_gpio_out", 32'(gpio_out), 32'd0);
      @(negedge clock);
    end
    gpio_in[0] = 1'b1;
    @(negedge clock);
    chk("release_pc_hold", pc, RESET_PC);
    @(negedge clock);
    run_check(480, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
